video_timing_gen: RTL and testbench

Generates 640x480@60 (parameterisable) raster timing and an optional colour-bar test pattern for the DVI transmit path. It sits directly upstream of the three per-channel TMDS encoders. `de` and `rgb` feed each encoder's `de`/`i_data`. `hsync`/`vsync` feed the blue-channel encoder's `ctrl_1`/`ctrl_2`. The green/red encoders' control inputs are tied 0 by the integrator. All outputs are registered and mutually aligned, so encoder latency applies uniformly.

---
 rtl/video_timing_gen.sv | 140 ++++++++++++++
 tb/tb_video_timing_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator (default 640x480@60) with registered, mutually aligned outputs.
// Define VTG_COLORBAR_EN to drive an eight-bar colour pattern on r/g/b; otherwise r/g/b stay 0.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        h_wrap;
    logic        active;
    logic        hs_act;
    logic        vs_act;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    // Sync windows decode the counters directly, so vsync moves only at h_cnt = 0.
    always_comb begin
        active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            de          <= active;
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            frame_start <= (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
            pix_x       <= active ? h_cnt_q : 12'd0;
            pix_y       <= active ? v_cnt_q : 12'd0;
        end
    end

`ifdef VTG_COLORBAR_EN
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    logic [11:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Sub-counter tracks h_cnt: restarts with the line, steps the bar index every BAR_W pixels.
    always_comb begin
        bar_cnt_d = bar_cnt_q + 12'd1;
        bar_idx_d = bar_idx_q;
        if (h_wrap) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end
    end

    // Bar order W,Y,C,G,M,R,B,K maps to r=~idx[1], g=~idx[2], b=~idx[0].
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= (active && !bar_idx_q[1]) ? 8'hFF : 8'h00;
            g <= (active && !bar_idx_q[2]) ? 8'hFF : 8'h00;
            b <= (active && !bar_idx_q[0]) ? 8'hFF : 8'h00;
        end
    end
`else
    always_comb begin
        r = '0;
        g = '0;
        b = '0;
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line/bar checks, a small-raster
// instance with active-high syncs for frame timing and mid-frame reset.
`timescale 1ns/1ps
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rstn_s = 1'b0;
    logic        de, hsync, vsync, frame_start;
    logic [11:0] pix_x, pix_y;
    logic [7:0]  r, g, b;
    logic        de_s, hsync_s, vsync_s, frame_start_s;
    logic [11:0] pix_x_s, pix_y_s;
    logic [7:0]  r_s, g_s, b_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    video_timing_gen dut (
        .clk(clk), .rstn(rstn), .de(de), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y), .r(r), .g(g), .b(b)
    );

    // 16+2+3+4 = 25 pixels/line, 6+2+2+3 = 13 lines/frame, 325 cycles/frame, bar width 2.
    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .clk(clk), .rstn(rstn_s), .de(de_s), .hsync(hsync_s), .vsync(vsync_s),
        .frame_start(frame_start_s), .pix_x(pix_x_s), .pix_y(pix_y_s),
        .r(r_s), .g(g_s), .b(b_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [11:0] x, input int bar_w);
`ifdef VTG_COLORBAR_EN
        case (int'(x) / bar_w)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return 24'h000000;
`endif
    endfunction

    initial begin
        int de_hi, de_fall, hs_first, hs_len, vs_len, blank_bad, rgb_bad;
        int pulses, fs_cnt, vs_first;
        logic de_prev;
        bit found;

        // Reset values, default instance (active-low syncs idle high).
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_de", 32'(de), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_pix", 32'({pix_x, pix_y}), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_s_hsync", 32'(hsync_s), 32'd0);
        check("rst_s_vsync", 32'(vsync_s), 32'd0);

        rstn = 1'b1;
        de_hi = 0; de_fall = -1; hs_first = -1; hs_len = 0; vs_len = 0;
        blank_bad = 0; rgb_bad = 0;
        for (int cyc = 0; cyc <= 800; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                check("first_de", 32'(de), 32'd1);
                check("first_fs", 32'(frame_start), 32'd1);
                check("first_pix", 32'({pix_x, pix_y}), 32'd0);
                check("first_rgb", 32'({r, g, b}), 32'(exp_rgb(12'd0, 80)));
            end
            if (cyc < 800) begin
                if (de) de_hi++;
                else if (de_fall < 0) de_fall = cyc;
                if (!hsync) begin
                    hs_len++;
                    if (hs_first < 0) hs_first = cyc;
                end
                if (!vsync) vs_len++;
                if (!de && ({r, g, b} != 24'd0 || pix_x != 12'd0 || pix_y != 12'd0)) blank_bad++;
                if (de && {r, g, b} != exp_rgb(pix_x, 80)) rgb_bad++;
                if (cyc == 79 || cyc == 80 || cyc == 400 || cyc == 639) begin
                    check($sformatf("bar_x%0d", cyc), 32'({r, g, b}),
                          32'(exp_rgb(12'(cyc), 80)));
                    check($sformatf("pix_x%0d", cyc), 32'(pix_x), 32'(cyc));
                end
            end else begin
                check("de_period", 32'(de), 32'd1);
                check("line1_pix_y", 32'(pix_y), 32'd1);
                check("line1_fs", 32'(frame_start), 32'd0);
            end
        end
        check("de_high_cycles", 32'(de_hi), 32'd640);
        check("de_fall_at", 32'(de_fall), 32'd640);
        check("hsync_start", 32'(hs_first), 32'd656);
        check("hsync_len", 32'(hs_len), 32'd96);
        check("vsync_line0", 32'(vs_len), 32'd0);
        check("blank_zero", 32'(blank_bad), 32'd0);
        check("rgb_line0", 32'(rgb_bad), 32'd0);

        // Small raster: one full frame plus the next frame_start.
        @(negedge clk);
        rstn_s = 1'b1;
        de_hi = 0; pulses = 0; vs_len = 0; vs_first = -1; hs_first = -1; hs_len = 0;
        fs_cnt = 0; blank_bad = 0; rgb_bad = 0; de_prev = 1'b0;
        for (int cyc = 0; cyc <= 325; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 325) begin
                if (de_s) de_hi++;
                if (de_s && !de_prev) pulses++;
                if (vsync_s) begin
                    vs_len++;
                    if (vs_first < 0) vs_first = cyc;
                end
                if (hsync_s) begin
                    hs_len++;
                    if (hs_first < 0) hs_first = cyc;
                end
                if (frame_start_s && cyc != 0) fs_cnt++;
                if (!de_s && {r_s, g_s, b_s} != 24'd0) blank_bad++;
                if (de_s && {r_s, g_s, b_s} != exp_rgb(pix_x_s, 2)) rgb_bad++;
            end else begin
                check("s_next_fs", 32'(frame_start_s), 32'd1);
            end
            de_prev = de_s;
        end
        check("s_de_pulses", 32'(pulses), 32'd6);
        check("s_de_total", 32'(de_hi), 32'd96);
        check("s_vsync_len", 32'(vs_len), 32'd50);
        check("s_vsync_start", 32'(vs_first), 32'd200);
        check("s_hsync_start", 32'(hs_first), 32'd18);
        check("s_hsync_total", 32'(hs_len), 32'd39);
        check("s_stray_fs", 32'(fs_cnt), 32'd0);
        check("s_blank_rgb", 32'(blank_bad), 32'd0);
        check("s_rgb", 32'(rgb_bad), 32'd0);

        // Mid-frame reset at line 3, pixel 5.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (de_s && pix_y_s == 12'd3 && pix_x_s == 12'd5) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("s_mid_found", 32'(found), 32'd1);
        @(negedge clk);
        rstn_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("s_mid_rst%0d", i),
                  32'({de_s, hsync_s, vsync_s, frame_start_s, pix_x_s, pix_y_s, r_s}), 32'd0);
        end
        @(negedge clk);
        rstn_s = 1'b1;
        fs_cnt = 0;
        for (int cyc = 0; cyc <= 325; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                check("s_restart_fs", 32'(frame_start_s), 32'd1);
                check("s_restart_de", 32'(de_s), 32'd1);
                check("s_restart_pix", 32'({pix_x_s, pix_y_s}), 32'd0);
            end else if (cyc < 325) begin
                if (frame_start_s) fs_cnt++;
            end else begin
                check("s_restart_next_fs", 32'(frame_start_s), 32'd1);
            end
        end
        check("s_restart_stray_fs", 32'(fs_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
